// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   // Largest value of a ones digit and of a tens digit in MM:SS
   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
   } sw_time_t;

   localparam sw_time_t TIME_ZERO = '0;
   localparam sw_time_t TIME_MAX  = '{mt: TENS_MAX, mo: ONES_MAX, st: TENS_MAX, so: ONES_MAX};

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer plus rising-edge detector. Produces a one-cycle event
// per press. The detector only arms once a genuine low level has travelled
// through the synchronizer after reset, so a button already held during
// reset does not fire until it is released and pressed again.
// SYNC_STAGES must be at least 2.
module btn_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic event_out
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic [SYNC_STAGES-1:0] fill_p;
   logic                   prev;
   logic                   armed;
   logic                   level;
   logic                   fill_done;

   assign level     = sync_p[SYNC_STAGES-1];
   assign fill_done = fill_p[SYNC_STAGES-1];

   // Synchronizer chain, fill tracker, previous level and arming flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p <= '0;
         fill_p <= '0;
         prev   <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], btn_in};
         fill_p <= {fill_p[SYNC_STAGES-2:0], 1'b1};
         prev   <= level;
         armed  <= armed | (fill_done & ~level);
      end
   end

   // Rising edge of the synchronized level, once armed
   always_comb begin
      event_out = fill_done & armed & level & ~prev;
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, MM:SS BCD counter, lap hold
// register and display mux feeding the seven-segment driver.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_ss,
   input  logic       btn_clr,
   input  logic       btn_lap,
   output logic [3:0] disp_mt,
   output logic [3:0] disp_mo,
   output logic [3:0] disp_st,
   output logic [3:0] disp_so,
   output logic       running,
   output logic       lap_active,
   output logic       wrap
);

   sw_state_t state, next_state;
   sw_time_t  live, hold, shown;
   logic      ev_ss, ev_clr, ev_lap;
   logic      count_en, zero_cnt, clr_flags, lap_toggle;

   // BCD increment with full MM:SS cascade; 59:59 rolls to 00:00
   function automatic sw_time_t bcd_inc(input sw_time_t t);
      sw_time_t r;
      r = t;
      if (t.so != ONES_MAX) begin
         r.so = t.so + 4'd1;
      end else begin
         r.so = 4'd0;
         if (t.st != TENS_MAX) begin
            r.st = t.st + 4'd1;
         end else begin
            r.st = 4'd0;
            if (t.mo != ONES_MAX) begin
               r.mo = t.mo + 4'd1;
            end else begin
               r.mo = 4'd0;
               r.mt = (t.mt != TENS_MAX) ? t.mt + 4'd1 : 4'd0;
            end
         end
      end
      return r;
   endfunction

   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_ss  (.clk(clk), .rst(rst), .btn_in(btn_ss),  .event_out(ev_ss));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_clr (.clk(clk), .rst(rst), .btn_in(btn_clr), .event_out(ev_clr));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_lap (.clk(clk), .rst(rst), .btn_in(btn_lap), .event_out(ev_lap));

   // State register; running is registered alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= next_state;
         running <= (next_state == RUN);
      end
   end

   // Next-state logic; clear beats start/stop while paused
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ev_ss) next_state = RUN;
         RUN:     if (ev_ss) next_state = PAUSE;
         PAUSE: begin
            if (ev_clr)     next_state = IDLE;
            else if (ev_ss) next_state = RUN;
         end
         default: next_state = IDLE;
      endcase
   end

   // Control strobes decoded from the registered state and button events
   always_comb begin
      count_en   = (state == RUN) & tick;
      zero_cnt   = (state != RUN) & ev_clr;
      clr_flags  = (state != RUN) & ev_clr;
      lap_toggle = (state == RUN) & ev_lap;
   end

   // Live count, lap hold register and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live       <= TIME_ZERO;
         hold       <= TIME_ZERO;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         if (zero_cnt)      live <= TIME_ZERO;
         else if (count_en) live <= bcd_inc(live);

         if (lap_toggle && !lap_active) hold <= live;

         if (clr_flags)       lap_active <= 1'b0;
         else if (lap_toggle) lap_active <= ~lap_active;

         if (clr_flags)                          wrap <= 1'b0;
         else if (count_en && live == TIME_MAX)  wrap <= 1'b1;
      end
   end

   // Display shows the frozen lap value while a lap is held
   always_comb begin
      shown   = lap_active ? hold : live;
      disp_mt = shown.mt;
      disp_mo = shown.mo;
      disp_st = shown.st;
      disp_so = shown.so;
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl. A seconds-based reference model
// predicts the outputs after every clock edge; a monitor compares them.
module tb_stopwatch_ctrl;

   localparam int S    = 2;
   localparam int MAXN = 20000;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick, btn_ss, btn_clr, btn_lap;
   logic [3:0] disp_mt, disp_mo, disp_st, disp_so;
   logic       running, lap_active, wrap;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
      .disp_mt(disp_mt), .disp_mo(disp_mo), .disp_st(disp_st), .disp_so(disp_so),
      .running(running), .lap_active(lap_active), .wrap(wrap)
   );

   typedef struct packed {
      logic [15:0] disp;
      logic        run;
      logic        lap;
      logic        wrp;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 idle, 1 running, 2 paused; times in seconds
   int m_mode, m_secs, m_hold;
   bit m_lap, m_wrap;
   int n;
   bit h_ss [0:MAXN];
   bit h_clr[0:MAXN];
   bit h_lap[0:MAXN];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_disp(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // A press registers on edge idx when two post-reset samples S edges back show 0 then 1
   function automatic bit ev_at(input int which, input int idx);
      bit a, b;
      if (idx - S - 1 < 1) return 1'b0;
      case (which)
         0:       begin a = h_ss[idx-S];  b = h_ss[idx-S-1];  end
         1:       begin a = h_clr[idx-S]; b = h_clr[idx-S-1]; end
         default: begin a = h_lap[idx-S]; b = h_lap[idx-S-1]; end
      endcase
      return a & !b;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_secs = 0; m_hold = 0; m_lap = 0; m_wrap = 0; n = 0;
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.disp = m_lap ? to_disp(m_hold) : to_disp(m_secs);
      o.run  = (m_mode == 1);
      o.lap  = m_lap;
      o.wrp  = m_wrap;
      return o;
   endfunction

   task automatic model_edge(input bit t);
      bit e_ss, e_clr, e_lap, cnt, clrf;
      int old_mode;
      e_ss  = ev_at(0, n);
      e_clr = ev_at(1, n);
      e_lap = ev_at(2, n);
      old_mode = m_mode;
      cnt  = (old_mode == 1) && t;
      clrf = e_clr && (old_mode != 1);
      if (old_mode == 1 && e_lap) begin
         if (!m_lap) begin m_hold = m_secs; m_lap = 1; end
         else m_lap = 0;
      end
      if (clrf) m_lap = 0;
      if (clrf) m_wrap = 0;
      else if (cnt && m_secs == 3599) m_wrap = 1;
      if (clrf) m_secs = 0;
      else if (cnt) m_secs = (m_secs + 1) % 3600;
      case (old_mode)
         0: if (e_ss) m_mode = 1;
         1: if (e_ss) m_mode = 2;
         default: if (e_clr) m_mode = 0; else if (e_ss) m_mode = 1;
      endcase
   endtask

   // Called at a negedge: drive inputs for the next edge, predict, wait
   task automatic step(input bit t, input bit ss, input bit clr, input bit lap);
      tick = t; btn_ss = ss; btn_clr = clr; btn_lap = lap;
      if (n < MAXN) n++;
      h_ss[n] = ss; h_clr[n] = clr; h_lap[n] = lap;
      model_edge(t);
      exp_q.push_back(model_obs());
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      repeat (k) step(0, 0, 0, 0);
   endtask

   task automatic ticks(input int k);
      repeat (k) step(1, 0, 0, 0);
   endtask

   // which: 0 start/stop, 1 clear, 2 lap; returns after the event has taken effect
   task automatic press(input int which, input bit tick_on_event);
      step(0, which == 0, which == 1, which == 2);
      repeat (S - 1) step(0, 0, 0, 0);
      step(tick_on_event, 0, 0, 0);
   endtask

   task automatic chk_outputs(input string name, input logic [15:0] d,
                              input bit r, input bit l, input bit w);
      chk(name, {13'd0, disp_mt, disp_mo, disp_st, disp_so, running, lap_active, wrap},
          {13'd0, d, r, l, w});
   endtask

   // Monitor: compares DUT outputs after each modelled edge
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {disp_mt, disp_mo, disp_st, disp_so, running, lap_active, wrap};
            chk("cycle", 32'(g), 32'(e));
         end
      end
   end

   initial begin
      rst = 1'b1; tick = 0; btn_ss = 0; btn_clr = 0; btn_lap = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_outputs("reset_outputs", 16'h0000, 0, 0, 0);
      rst = 1'b0;
      idle(4);

      // Start and count 75 s
      press(0, 0);
      ticks(75);
      idle(1);
      chk_outputs("count_01_15", 16'h0115, 1, 0, 0);

      // Run up to 59:58 then wrap
      ticks(3598 - 75);
      idle(1);
      chk_outputs("count_59_58", 16'h5958, 1, 0, 0);
      ticks(2);
      idle(1);
      chk_outputs("wrap_00_00", 16'h0000, 1, 0, 1);
      press(0, 0);
      press(1, 0);
      chk_outputs("clear_wrap", 16'h0000, 0, 0, 0);

      // Lap freeze and release
      press(0, 0);
      ticks(10);
      press(2, 0);
      ticks(5);
      idle(1);
      chk_outputs("lap_frozen", 16'h0010, 1, 1, 0);
      press(2, 0);
      chk_outputs("lap_release", 16'h0015, 1, 0, 0);

      // Tick on the stop edge counts; tick on the resume edge does not
      press(0, 1);
      chk_outputs("tick_on_stop", 16'h0016, 0, 0, 0);
      press(0, 1);
      chk_outputs("tick_on_resume", 16'h0016, 1, 0, 0);

      // Simultaneous start/stop and clear while paused, clear ignored in run
      press(0, 0);
      step(0, 1, 1, 0);
      idle(S);
      chk_outputs("ss_clr_pause", 16'h0000, 0, 0, 0);
      press(0, 0);
      ticks(3);
      press(1, 0);
      chk_outputs("clr_in_run", 16'h0003, 1, 0, 0);

      // Randomized phase
      begin
         bit ss, clr, lap;
         ss = 0; clr = 0; lap = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ss  = ~ss;
            if ($urandom_range(0, 39) == 0) clr = ~clr;
            if ($urandom_range(0, 19) == 0) lap = ~lap;
            step($urandom_range(0, 2) == 0, ss, clr, lap);
         end
         idle(4);
      end

      // Asynchronous reset mid-count with a lap held at 12:34
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(4);
      press(0, 0);
      ticks(754);
      press(2, 0);
      ticks(7);
      idle(1);
      chk_outputs("lap_12_34", 16'h1234, 1, 1, 0);
      #1;
      rst = 1'b1;
      btn_ss = 1'b1;
      #1;
      chk_outputs("async_reset", 16'h0000, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) step(0, 1, 0, 0);
      chk_outputs("held_no_event", 16'h0000, 0, 0, 0);
      idle(2);
      press(0, 0);
      chk_outputs("press_after_release", 16'h0000, 1, 0, 0);
      ticks(2);
      idle(1);

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
